// File: rtl/rv32i_lsu.sv
// Load/store unit between EX and WB: drives a req/ack data bus, extends loads,
// lanes stores, and registers non-memory results straight through to WB.
//   state | meaning
//   IDLE  | pass EX results to WB, or launch a bus op
//   BUSY  | bus request outstanding, waiting for mem_ack or timeout
//   DONE  | result visible on wb_*, pipeline released
module rv32i_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we,
  input  logic [4:0]  ex_waddr,
  input  logic [2:0]  ex_alufun3,
  input  logic [31:0] ex_alures,
  input  logic        ex_memce,
  input  logic        ex_memwe,
  input  logic [31:0] ex_memdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_data,
  output logic        lsu_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [7:0] CNT_TC  = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        l_we;
  logic        l_load;
  logic [4:0]  l_waddr;
  logic [2:0]  l_fun3;
  logic [1:0]  l_off;
  logic        legal;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    legal     = 1'b1;
    be_nxt    = 4'b1111;
    wdata_nxt = ex_memdata;
    case (ex_alufun3)
      3'b000: begin
        if (ex_memwe) begin
          be_nxt    = 4'b0001 << ex_alures[1:0];
          wdata_nxt = {4{ex_memdata[7:0]}};
        end
      end
      3'b001: begin
        legal = ~ex_alures[0];
        if (ex_memwe) begin
          be_nxt    = ex_alures[1] ? 4'b1100 : 4'b0011;
          wdata_nxt = {2{ex_memdata[15:0]}};
        end
      end
      3'b010:  legal = (ex_alures[1:0] == 2'b00);
      3'b100:  legal = ~ex_memwe;
      3'b101:  legal = ~ex_memwe & ~ex_alures[0];
      default: legal = 1'b0;
    endcase
  end

  // Gated with rst so the stall drops the instant reset asserts.
  assign stall = rst & (((state == ST_IDLE) & ex_memce & legal) | (state == ST_BUSY));

  always_comb begin
    ld_byte = mem_rdata[{l_off, 3'b000} +: 8];
    ld_half = l_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (l_fun3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      l_we      <= 1'b0;
      l_load    <= 1'b0;
      l_waddr   <= 5'd0;
      l_fun3    <= 3'd0;
      l_off     <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      wb_we     <= 1'b0;
      wb_waddr  <= 5'd0;
      wb_data   <= 32'd0;
      lsu_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!ex_memce) begin
            wb_we    <= ex_we;
            wb_waddr <= ex_waddr;
            wb_data  <= ex_alures;
            lsu_err  <= 1'b0;
          end else if (!legal) begin
            wb_we   <= 1'b0;
            lsu_err <= 1'b1;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= ex_memwe;
            mem_addr  <= {ex_alures[31:2], 2'b00};
            mem_be    <= be_nxt;
            mem_wdata <= wdata_nxt;
            l_we      <= ex_we;
            l_load    <= ~ex_memwe;
            l_waddr   <= ex_waddr;
            l_fun3    <= ex_alufun3;
            l_off     <= ex_alures[1:0];
            wb_we     <= 1'b0;
            lsu_err   <= 1'b0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt <= cnt + 8'd1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= ST_DONE;
            if (l_load) begin
              wb_we    <= l_we;
              wb_waddr <= l_waddr;
              wb_data  <= ld_data;
            end else begin
              wb_we <= 1'b0;
            end
          end else if (cnt == CNT_TC) begin
            mem_req <= 1'b0;
            lsu_err <= 1'b1;
            wb_we   <= 1'b0;
            state   <= ST_DONE;
          end
        end
        default: begin
          // wb_we is a single-cycle strobe so the load is not written back twice.
          cnt     <= 8'd0;
          lsu_err <= 1'b0;
          wb_we   <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
